seq_acc_sched: RTL and testbench

//  Job sequencer in front of seq_acc. On start, fetches num_vectors input vectors from activation SRAM,

---
 rtl/seq_acc_sched.sv | 217 +++++++++++++++++++++
 tb/tb_seq_acc_sched.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_acc_sched.sv
// Job sequencer in front of seq_acc: fetches N activation vectors, issues them, writes results out.
// Latency: 3 cycles minimum per issued vector (FETCH, LOAD, ISSUE); results written 1 cycle after acc_valid_i.
// Backpressure: mac_ready_i stalls issue with mac_data_o held; results cannot be stalled. Optional SEQ_ACC_SCHED_PERF_EN adds perf counters.
module seq_acc_sched #(
  parameter int inputElements   = 128,
  parameter int maxInputBits    = 8,
  parameter int outputElements  = 32,
  parameter int accumulatorBits = 16,
  parameter int addrBits        = 10,
  parameter int cntBits         = 16
) (
  input  logic                                       clk,
  input  logic                                       nrst,
  input  logic                                       start_i,
  input  logic [cntBits-1:0]                         num_vectors_i,
  input  logic [addrBits-1:0]                        in_base_i,
  input  logic [addrBits-1:0]                        out_base_i,
  output logic                                       busy_o,
  output logic                                       done_o,
  output logic                                       err_o,
  output logic                                       act_rd_en_o,
  output logic [addrBits-1:0]                        act_rd_addr_o,
  input  logic [inputElements*maxInputBits-1:0]      act_rd_data_i,
  output logic [inputElements*maxInputBits-1:0]      mac_data_o,
  output logic                                       mac_valid_o,
  input  logic                                       mac_ready_i,
  input  logic                                       acc_valid_i,
  input  logic [outputElements*accumulatorBits-1:0]  acc_data_i,
  output logic                                       out_wr_en_o,
  output logic [addrBits-1:0]                        out_wr_addr_o,
  output logic [outputElements*accumulatorBits-1:0]  out_wr_data_o
`ifdef SEQ_ACC_SCHED_PERF_EN
  ,
  output logic [31:0]                                perf_cycles_o,
  output logic [31:0]                                perf_stall_o
`endif
);

  localparam int ActW = inputElements * maxInputBits;
  localparam int AccW = outputElements * accumulatorBits;
  localparam logic [cntBits-1:0] CntOne = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [cntBits-1:0]    n_q;
  logic [addrBits-1:0]   in_base_q;
  logic [addrBits-1:0]   out_base_q;
  logic [cntBits-1:0]    issued_q;
  logic [cntBits-1:0]    collected_q;
  logic [ActW-1:0]       mac_data_q;
  logic                  err_q;
  logic                  wr_en_q;
  logic [addrBits-1:0]   wr_addr_q;
  logic [AccW-1:0]       wr_data_q;

  logic start_acc;
  logic issue_hs;
  logic acc_take;

  // A start is only honoured in IDLE; a result is only accepted if one is outstanding.
  assign start_acc = (state_q == S_IDLE) && start_i;
  assign issue_hs  = (state_q == S_ISSUE) && mac_ready_i;
  assign acc_take  = acc_valid_i && (collected_q < issued_q);

  // Next-state and decoded control outputs.
  always_comb begin
    state_d       = state_q;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    act_rd_en_o   = 1'b0;
    act_rd_addr_o = '0;
    mac_valid_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          state_d = (num_vectors_i != '0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: begin
        act_rd_en_o   = 1'b1;
        act_rd_addr_o = in_base_q + issued_q[addrBits-1:0];
        state_d       = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        mac_valid_o = 1'b1;
        if (mac_ready_i) begin
          state_d = ((issued_q + CntOne) < n_q) ? S_FETCH : S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The last write strobe is already on the bus when collected_q reaches n_q.
        if (collected_q == n_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Job parameters and issue counter, latched/cleared on an accepted start.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      n_q        <= '0;
      in_base_q  <= '0;
      out_base_q <= '0;
      issued_q   <= '0;
    end else if (start_acc) begin
      n_q        <= num_vectors_i;
      in_base_q  <= in_base_i;
      out_base_q <= out_base_i;
      issued_q   <= '0;
    end else if (issue_hs) begin
      issued_q <= issued_q + CntOne;
    end
  end

  // Issue data register: loaded one cycle after the SRAM strobe, held through ISSUE.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mac_data_q <= '0;
    end else if (state_q == S_LOAD) begin
      mac_data_q <= act_rd_data_i;
    end
  end

  // Result collection runs in every state so late results are never dropped silently.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      collected_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      wr_en_q <= acc_take;
      if (start_acc) begin
        collected_q <= '0;
      end else if (acc_take) begin
        collected_q <= collected_q + CntOne;
      end
      if (acc_take) begin
        wr_addr_q <= out_base_q + collected_q[addrBits-1:0];
        wr_data_q <= acc_data_i;
      end
    end
  end

  // Sticky error for unsolicited results; cleared by a new job, but a same-cycle stray result still sets it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_q <= 1'b0;
    end else if (acc_valid_i && !acc_take) begin
      err_q <= 1'b1;
    end else if (start_acc) begin
      err_q <= 1'b0;
    end
  end

  assign err_o         = err_q;
  assign mac_data_o    = mac_data_q;
  assign out_wr_en_o   = wr_en_q;
  assign out_wr_addr_o = wr_addr_q;
  assign out_wr_data_o = wr_data_q;

`ifdef SEQ_ACC_SCHED_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [31:0] perf_stall_q;

  // Busy and issue-stall cycle counters; saturating, cleared on start, frozen while idle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else if (start_acc) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if ((state_q != S_IDLE) && (perf_cycles_q != '1)) begin
        perf_cycles_q <= perf_cycles_q + 32'd1;
      end
      if ((state_q == S_ISSUE) && !mac_ready_i && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_cycles_o = perf_cycles_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_seq_acc_sched.sv
// Directed bench for seq_acc_sched with an activation SRAM model and a fixed-latency seq_acc model.
// Inputs change 1 time unit after the rising edge; outputs are sampled there or on the falling edge.
// Results return 12 cycles after each issue handshake.
module tb_seq_acc_sched;

  localparam int ActW = 1024;
  localparam int AccW = 512;

  logic              clk;
  logic              nrst;
  logic              start_i;
  logic [15:0]       num_vectors_i;
  logic [9:0]        in_base_i;
  logic [9:0]        out_base_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic              act_rd_en_o;
  logic [9:0]        act_rd_addr_o;
  logic [ActW-1:0]   act_rd_data_i;
  logic [ActW-1:0]   mac_data_o;
  logic              mac_valid_o;
  logic              mac_ready_i;
  logic              acc_valid_i;
  logic [AccW-1:0]   acc_data_i;
  logic              out_wr_en_o;
  logic [9:0]        out_wr_addr_o;
  logic [AccW-1:0]   out_wr_data_o;

  logic              man_vld;
  logic [AccW-1:0]   man_dat;
  logic [11:0]       vld_pipe;
  logic [AccW-1:0]   dat_pipe [12];

  logic [9:0]        rd_q [$];
  logic [9:0]        wa_q [$];
  logic [AccW-1:0]   wd_q [$];
  int                done_cnt;
  int                hs_cnt;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  seq_acc_sched dut (
    .clk           (clk),
    .nrst          (nrst),
    .start_i       (start_i),
    .num_vectors_i (num_vectors_i),
    .in_base_i     (in_base_i),
    .out_base_i    (out_base_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .act_rd_en_o   (act_rd_en_o),
    .act_rd_addr_o (act_rd_addr_o),
    .act_rd_data_i (act_rd_data_i),
    .mac_data_o    (mac_data_o),
    .mac_valid_o   (mac_valid_o),
    .mac_ready_i   (mac_ready_i),
    .acc_valid_i   (acc_valid_i),
    .acc_data_i    (acc_data_i),
    .out_wr_en_o   (out_wr_en_o),
    .out_wr_addr_o (out_wr_addr_o),
    .out_wr_data_o (out_wr_data_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Activation contents as a function of address: lane i holds addr[7:0]+i, top lane holds addr[9:8].
  function automatic logic [ActW-1:0] act_pat(input logic [9:0] a);
    logic [ActW-1:0] p;
    for (int i = 0; i < 127; i++) p[i*8 +: 8] = a[7:0] + 8'(i);
    p[127*8 +: 8] = {6'b0, a[9:8]};
    return p;
  endfunction

  // Stand-in for the seq_acc arithmetic.
  function automatic logic [AccW-1:0] res_of(input logic [ActW-1:0] v);
    return v[AccW-1:0] ^ {16{32'hA5C3_0F96}};
  endfunction

  // Activation SRAM: read data one cycle after the strobe.
  always @(posedge clk) begin
    if (act_rd_en_o) act_rd_data_i <= act_pat(act_rd_addr_o);
  end

  // seq_acc model: fixed pipeline from issue handshake to result, flushed by reset.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[10:0], mac_valid_o && mac_ready_i};
      dat_pipe[0] <= res_of(mac_data_o);
      for (int k = 1; k < 12; k++) dat_pipe[k] <= dat_pipe[k-1];
    end
  end

  assign acc_valid_i = vld_pipe[11] | man_vld;
  assign acc_data_i  = man_vld ? man_dat : dat_pipe[11];

  // Bus monitor on the falling edge.
  always @(negedge clk) begin
    if (act_rd_en_o) rd_q.push_back(act_rd_addr_o);
    if (out_wr_en_o) begin
      wa_q.push_back(out_wr_addr_o);
      wd_q.push_back(out_wr_data_o);
    end
    if (done_o) done_cnt <= done_cnt + 1;
    if (mac_valid_o && mac_ready_i) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    done_cnt = 0;
    hs_cnt   = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [ActW-1:0] obs, input logic [ActW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed low %h expected low %h", tag, obs[255:0], exp[255:0]);
    end
  endtask

  task automatic start_job(input logic [15:0] n, input logic [9:0] ib, input logic [9:0] ob);
    num_vectors_i = n;
    in_base_i     = ib;
    out_base_i    = ob;
    start_i       = 1'b1;
    tick();
    start_i       = 1'b0;
    num_vectors_i = 16'h00FF;
    in_base_i     = 10'h155;
    out_base_i    = 10'h2AA;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (done_o) seen = 1'b1;
      else tick();
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic check_job(input string tag, input int n, input logic [9:0] ib, input logic [9:0] ob,
                           input int rb, input int wb, input int db);
    chk({tag, " rd count"}, 32'(rd_q.size() - rb), 32'(n));
    chk({tag, " wr count"}, 32'(wa_q.size() - wb), 32'(n));
    chk({tag, " done count"}, 32'(done_cnt - db), 32'd1);
    chk({tag, " busy after"}, 32'(busy_o), 32'd0);
    for (int i = 0; i < n; i++) begin
      logic [9:0] ra;
      logic [9:0] wa;
      ra = ib + 10'(i);
      wa = ob + 10'(i);
      chk($sformatf("%s rd%0d", tag, i), 32'(rd_q[rb+i]), 32'(ra));
      chk($sformatf("%s wa%0d", tag, i), 32'(wa_q[wb+i]), 32'(wa));
      chkw($sformatf("%s wd%0d", tag, i), ActW'(wd_q[wb+i]), ActW'(res_of(act_pat(ra))));
    end
  endtask

  initial begin
    int rb;
    int wb;
    int db;
    int hb;
    bit seen;

    nrst          = 1'b0;
    start_i       = 1'b0;
    num_vectors_i = '0;
    in_base_i     = '0;
    out_base_i    = '0;
    mac_ready_i   = 1'b1;
    man_vld       = 1'b0;
    man_dat       = '0;

    // Reset state.
    repeat (3) tick();
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst done", 32'(done_o), 32'd0);
    chk("rst err", 32'(err_o), 32'd0);
    chk("rst mac_valid", 32'(mac_valid_o), 32'd0);
    chk("rst rd_en", 32'(act_rd_en_o), 32'd0);
    chk("rst wr_en", 32'(out_wr_en_o), 32'd0);
    chkw("rst mac_data", mac_data_o, '0);
    nrst = 1'b1;
    tick();

    // Basic four-vector job.
    rb = rd_q.size(); wb = wa_q.size(); db = done_cnt;
    start_job(16'd4, 10'h010, 10'h200);
    chk("t1 busy", 32'(busy_o), 32'd1);
    wait_done("t1 done seen", 300);
    tick();
    check_job("t1", 4, 10'h010, 10'h200, rb, wb, db);
    chk("t1 err", 32'(err_o), 32'd0);

    // Empty job: one DONE cycle, no traffic.
    rb = rd_q.size(); wb = wa_q.size(); db = done_cnt;
    start_job(16'd0, 10'h020, 10'h020);
    chk("t2 busy", 32'(busy_o), 32'd1);
    chk("t2 done", 32'(done_o), 32'd1);
    tick();
    chk("t2 busy after", 32'(busy_o), 32'd0);
    chk("t2 done after", 32'(done_o), 32'd0);
    repeat (3) tick();
    chk("t2 rd count", 32'(rd_q.size() - rb), 32'd0);
    chk("t2 wr count", 32'(wa_q.size() - wb), 32'd0);
    chk("t2 done count", 32'(done_cnt - db), 32'd1);

    // Stalled issue: data held for five cycles, exactly one handshake per vector.
    rb = rd_q.size(); wb = wa_q.size(); db = done_cnt; hb = hs_cnt;
    mac_ready_i = 1'b0;
    start_job(16'd2, 10'h020, 10'h100);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mac_valid_o) seen = 1'b1;
      else tick();
    end
    chk("t3 valid seen", 32'(seen), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t3 stall valid%0d", k), 32'(mac_valid_o), 32'd1);
      chkw($sformatf("t3 stall data%0d", k), mac_data_o, act_pat(10'h020));
      tick();
    end
    mac_ready_i = 1'b1;
    wait_done("t3 done seen", 300);
    tick();
    chk("t3 handshakes", 32'(hs_cnt - hb), 32'd2);
    check_job("t3", 2, 10'h020, 10'h100, rb, wb, db);

    // Address wrap on both SRAMs.
    rb = rd_q.size(); wb = wa_q.size(); db = done_cnt;
    start_job(16'd3, 10'h3FF, 10'h3FE);
    wait_done("t4 done seen", 300);
    tick();
    check_job("t4", 3, 10'h3FF, 10'h3FE, rb, wb, db);

    // Unsolicited result in IDLE sets err; next start clears it.
    wb = wa_q.size();
    man_dat = {16{32'hDEAD_BEEF}};
    man_vld = 1'b1;
    tick();
    man_vld = 1'b0;
    tick();
    chk("t5 err set", 32'(err_o), 32'd1);
    chk("t5 no write", 32'(wa_q.size() - wb), 32'd0);
    rb = rd_q.size(); wb = wa_q.size(); db = done_cnt;
    start_job(16'd1, 10'h000, 10'h000);
    chk("t5 err cleared", 32'(err_o), 32'd0);
    wait_done("t5 done seen", 300);
    tick();
    check_job("t5", 1, 10'h000, 10'h000, rb, wb, db);

    // Reset in DRAIN after two of four results.
    wb = wa_q.size(); db = done_cnt;
    start_job(16'd4, 10'h040, 10'h080);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (wa_q.size() - wb >= 2) seen = 1'b1;
      else tick();
    end
    chk("t6 two writes", 32'(seen), 32'd1);
    chk("t6 busy before rst", 32'(busy_o), 32'd1);
    nrst = 1'b0;
    #1;
    chk("t6 rst busy", 32'(busy_o), 32'd0);
    chk("t6 rst done", 32'(done_o), 32'd0);
    chk("t6 rst mac_valid", 32'(mac_valid_o), 32'd0);
    chk("t6 rst wr_en", 32'(out_wr_en_o), 32'd0);
    chk("t6 rst wr_addr", 32'(out_wr_addr_o), 32'd0);
    chkw("t6 rst mac_data", mac_data_o, '0);
    chkw("t6 rst wr_data", ActW'(out_wr_data_o), '0);
    repeat (2) tick();
    nrst = 1'b1;
    repeat (20) tick();
    chk("t6 no done", 32'(done_cnt - db), 32'd0);
    chk("t6 busy idle", 32'(busy_o), 32'd0);
    rb = rd_q.size(); wb = wa_q.size(); db = done_cnt;
    start_job(16'd1, 10'h005, 10'h006);
    chk("t6 restart busy", 32'(busy_o), 32'd1);
    wait_done("t6 done seen", 300);
    tick();
    check_job("t6", 1, 10'h005, 10'h006, rb, wb, db);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
